// File: rtl/sam_pro_pkg.sv
// Shared types and helpers for the sam_pro programmable 3-input logic cell.
// A truth table is indexed by {a,b,c}; bit i is the function value at index i.
package sam_pro_pkg;

    typedef logic [7:0] tt_t;
    typedef logic [2:0] idx_t;

    // Power-on function: ~b & (a | ~c)
    localparam tt_t TT_SILLY = 8'b0011_0001;

    function automatic logic tt_eval(input tt_t tt, input idx_t idx);
        logic bit_v;
        bit_v = 1'b0;
        case (idx)
            3'd0:    bit_v = tt[0];
            3'd1:    bit_v = tt[1];
            3'd2:    bit_v = tt[2];
            3'd3:    bit_v = tt[3];
            3'd4:    bit_v = tt[4];
            3'd5:    bit_v = tt[5];
            3'd6:    bit_v = tt[6];
            3'd7:    bit_v = tt[7];
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

endpackage

// File: rtl/sam_pro_if.sv
// Bundle of function inputs, table-load controls and results for sam_pro.
interface sam_pro_if;
    import sam_pro_pkg::*;

    logic a;
    logic b;
    logic c;
    logic in_valid;
    logic tt_load;
    tt_t  tt_data;
    logic y_comb;
    logic y;
    logic y_valid;

    modport master (
        output a, b, c, in_valid, tt_load, tt_data,
        input  y_comb, y, y_valid
    );

    modport slave (
        input  a, b, c, in_valid, tt_load, tt_data,
        output y_comb, y, y_valid
    );

endinterface

// File: rtl/sam_pro_lut.sv
// 8:1 selection of one truth-table bit by the 3-bit input index.
module sam_pro_lut
    import sam_pro_pkg::*;
(
    input  tt_t  tt,
    input  idx_t idx,
    output logic f
);

    // Pure mux; no state, so the result follows tt and idx with no clock
    always_comb begin
        f = tt_eval(tt, idx);
    end

endmodule

// File: rtl/sam_pro.sv
// Programmable 3-input Boolean cell: run-time reloadable truth table with a
// zero-latency result and a one-cycle registered result qualified by y_valid.
module sam_pro
    import sam_pro_pkg::*;
#(
    parameter tt_t TT_DEFAULT = TT_SILLY
)
(
    input  logic     clk,
    input  logic     rst_n,
    sam_pro_if.slave bus
);

    tt_t  tt_r;
    idx_t idx_s;
    logic f_s;
    logic y_r;
    logic y_valid_r;

    assign idx_s = {bus.a, bus.b, bus.c};

    sam_pro_lut u_lut (
        .tt  (tt_r),
        .idx (idx_s),
        .f   (f_s)
    );

    // Truth-table register; a load becomes visible only after the edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_r <= TT_DEFAULT;
        end else if (bus.tt_load) begin
            tt_r <= bus.tt_data;
        end else begin
            tt_r <= tt_r;
        end
    end

    // Registered result samples the pre-load table when load and valid coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r       <= 1'b0;
            y_valid_r <= 1'b0;
        end else begin
            y_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                y_r <= f_s;
            end else begin
                y_r <= y_r;
            end
        end
    end

    assign bus.y_comb  = f_s;
    assign bus.y       = y_r;
    assign bus.y_valid = y_valid_r;

endmodule

// File: tb/tb_sam_pro.sv
// Scoreboard bench for sam_pro: stimulus pushes expected registered results,
// a negedge monitor pops and compares them; y_comb is checked at drive time.
module tb_sam_pro;

    typedef struct packed {
        logic v;
        logic y;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    exp_t sb_q[$];
    logic [7:0] model_tt;
    logic       model_y;

    sam_pro_if bus ();

    sam_pro dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; exp_comb < 0 means use the model for y_comb
    task automatic drive(input logic ia, input logic ib, input logic ic,
                         input logic iv, input logic ld, input logic [7:0] data,
                         input int exp_comb);
        logic [2:0] idx;
        exp_t e;
        idx = {ia, ib, ic};
        bus.a = ia;
        bus.b = ib;
        bus.c = ic;
        bus.in_valid = iv;
        bus.tt_load = ld;
        bus.tt_data = data;
        #1;
        if (exp_comb >= 0) check("y_comb_directed", {7'd0, bus.y_comb}, exp_comb[7:0]);
        else               check("y_comb_model", {7'd0, bus.y_comb}, {7'd0, model_tt[idx]});
        if (iv) model_y = model_tt[idx];
        e.v = iv;
        e.y = model_y;
        sb_q.push_back(e);
        if (ld) model_tt = data;
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per active edge since the last reset
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("y_valid", {7'd0, bus.y_valid}, {7'd0, e.v});
                check("y", {7'd0, bus.y}, {7'd0, e.y});
            end else begin
                check("y_valid_idle", {7'd0, bus.y_valid}, 8'd0);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        model_tt = 8'h31;
        model_y = 1'b0;
        rst_n = 1'b0;
        bus.a = 1'b0;
        bus.b = 1'b0;
        bus.c = 1'b0;
        bus.in_valid = 1'b0;
        bus.tt_load = 1'b0;
        bus.tt_data = 8'h00;
        #12;
        check("rst_y", {7'd0, bus.y}, 8'd0);
        check("rst_y_valid", {7'd0, bus.y_valid}, 8'd0);
        rst_n = 1'b1;

        // Default-table sweep, no registered evaluation
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0);

        // Registered evaluation at idx 5, then hold with in_valid low
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1);

        // Load 0xFE: idx 0 -> 0, idx 7 -> 1
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1);

        // Load 0x00 and evaluate idx 4 on the same edge: old table wins
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);

        // Asynchronous reset between edges restores the default table
        bus.in_valid = 1'b0;
        bus.tt_load = 1'b0;
        bus.a = 1'b0;
        bus.b = 1'b0;
        bus.c = 1'b0;
        rst_n = 1'b0;
        sb_q.delete();
        model_tt = 8'h31;
        model_y = 1'b0;
        #1;
        check("midrst_y", {7'd0, bus.y}, 8'd0);
        check("midrst_y_valid", {7'd0, bus.y_valid}, 8'd0);
        check("midrst_y_comb_idx0", {7'd0, bus.y_comb}, 8'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0);

        // Random traffic against the scoreboard model
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)), -1);
        end
        bus.in_valid = 1'b0;
        bus.tt_load = 1'b0;
        @(negedge clk);
        #1;
        check("sb_drained", 8'(sb_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
